// File: rtl/calc_pkg.sv
// Shared calculator types: operator codes, ALU state encoding, default operand width.
// No logic; latency n/a.
// No handshake; consumers import it.
package calc_pkg;

   // Operand width shared by the input parser, this ALU and the result formatter
   localparam int CALC_DATA_WIDTH = 16;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } alu_state_t;

endpackage

// File: rtl/calc_alu_seq_divider.sv
// Restoring divider step: one quotient bit per enabled cycle, remainder/quotient held here.
// Latency: one bit per i_step; outputs show the value the next step will register.
// No backpressure; the parent sequences i_load/i_step. Built only with CALC_ALU_DIV_EN.
`ifdef CALC_ALU_DIV_EN
module seq_divider #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic             i_step,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_rem_nxt,
   output logic [WIDTH-1:0] o_quot_nxt
);

   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_sub;
   logic             w_ge;

   // Bring down the next dividend bit (MSB of the quotient shift register)
   assign w_shift = {r_rem, r_quot[WIDTH-1]};
   assign w_ge    = (w_shift >= {1'b0, i_divisor});
   assign w_sub   = w_shift - {1'b0, i_divisor};

   // Restored or reduced remainder is always below the divisor, so it fits WIDTH bits
   assign o_rem_nxt  = WIDTH'(w_ge ? w_sub : w_shift);
   assign o_quot_nxt = {r_quot[WIDTH-2:0], w_ge};

   // Partial remainder and quotient shift register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rem  <= '0;
         r_quot <= '0;
      end else if (i_load) begin
         r_rem  <= '0;
         r_quot <= i_dividend;
      end else if (i_step) begin
         r_rem  <= o_rem_nxt;
         r_quot <= o_quot_nxt;
      end
   end

endmodule
`endif

// File: rtl/calc_alu.sv
// Multi-cycle calculator ALU: add/sub in 1 compute cycle, shift-add mul and restoring div (CALC_ALU_DIV_EN) 1 bit/cycle.
// Latency: done_o 2 edges after start for add/sub/div-by-zero, DATA_WIDTH+1 edges for mul/div.
// No backpressure: start_calc_i is ignored while busy_o is high, nothing is queued.
module calc_alu
   import calc_pkg::*;
#(
   parameter int DATA_WIDTH = CALC_DATA_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH-1:0]   num1_i,
   input  logic [DATA_WIDTH-1:0]   num2_i,
   input  logic [1:0]              operator_i,
   input  logic                    start_calc_i,
   output logic                    busy_o,
   output logic [2*DATA_WIDTH-1:0] result_o,
   output logic                    negative_o,
   output logic                    err_o,
   output logic                    done_o
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   alu_state_t              r_state;
   alu_state_t              w_state_nxt;
   logic [DATA_WIDTH-1:0]   r_a;
   logic [DATA_WIDTH-1:0]   r_b;
   op_t                     r_op;
   logic [CW-1:0]           r_cnt;
   logic [2*DATA_WIDTH-1:0] r_acc;
   logic [2*DATA_WIDTH-1:0] r_result;
   logic                    r_neg;
   logic                    r_err;
   logic                    r_done;

   logic                    w_start;
   logic                    w_last;
   logic                    w_long_op;
   logic [DATA_WIDTH:0]     w_sum;
   logic                    w_lt;
   logic [DATA_WIDTH-1:0]   w_diff;
   logic [DATA_WIDTH:0]     w_mul_sum;
   logic [2*DATA_WIDTH-1:0] w_mul_nxt;
   logic [2*DATA_WIDTH-1:0] w_res;
   logic                    w_neg;
   logic                    w_err;

   assign w_start = (r_state == IDLE) && start_calc_i;
   assign w_last  = (r_state == CALC) && (r_cnt == '0);

   // Add/sub on the latched operands; subtract is sign-magnitude
   assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
   assign w_lt   = (r_a < r_b);
   assign w_diff = w_lt ? (r_b - r_a) : (r_a - r_b);

   // Shift-add multiply: accumulator is {partial product, remaining multiplier bits}
   assign w_mul_sum = {1'b0, r_acc[2*DATA_WIDTH-1:DATA_WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
   assign w_mul_nxt = {w_mul_sum, r_acc[DATA_WIDTH-1:1]};

`ifdef CALC_ALU_DIV_EN
   logic [DATA_WIDTH-1:0] w_div_rem;
   logic [DATA_WIDTH-1:0] w_div_quot;
   logic                  w_div_load;
   logic                  w_div_step;

   assign w_div_load = w_start && (op_t'(operator_i) == OP_DIV);
   assign w_div_step = (r_state == CALC) && (r_op == OP_DIV);

   seq_divider #(
      .WIDTH      (DATA_WIDTH)
   ) u_div (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_div_load),
      .i_step     (w_div_step),
      .i_dividend (num1_i),
      .i_divisor  (r_b),
      .o_rem_nxt  (w_div_rem),
      .o_quot_nxt (w_div_quot)
   );

   // Divide by zero collapses to a single compute cycle
   assign w_long_op = (op_t'(operator_i) == OP_MUL) ||
                      ((op_t'(operator_i) == OP_DIV) && (num2_i != '0));
`else
   assign w_long_op = (op_t'(operator_i) == OP_MUL);
`endif

   // Select the value the output registers take on the final compute edge
   always_comb begin
      w_res = '0;
      w_neg = 1'b0;
      w_err = 1'b0;
      case (r_op)
         OP_ADD: w_res = {{(DATA_WIDTH-1){1'b0}}, w_sum};
         OP_SUB: begin
            w_res = {{DATA_WIDTH{1'b0}}, w_diff};
            w_neg = w_lt;
         end
         OP_MUL: w_res = w_mul_nxt;
         OP_DIV: begin
`ifdef CALC_ALU_DIV_EN
            if (r_b == '0) begin
               w_err = 1'b1;
            end else begin
               w_res = {w_div_rem, w_div_quot};
            end
`else
            w_err = 1'b1;
`endif
         end
         default: ;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state: IDLE -> CALC on start, CALC -> DONE on last iteration, DONE -> IDLE
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start_calc_i) w_state_nxt = CALC;
         CALC:    if (r_cnt == '0)  w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Operand latch, iteration counter, accumulator and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= OP_ADD;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_result <= '0;
         r_neg    <= 1'b0;
         r_err    <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_start) begin
            r_a   <= num1_i;
            r_b   <= num2_i;
            r_op  <= op_t'(operator_i);
            r_acc <= {{DATA_WIDTH{1'b0}}, num1_i};
            r_cnt <= w_long_op ? CW'(DATA_WIDTH-1) : '0;
         end else if (r_state == CALC) begin
            r_acc <= w_mul_nxt;
            if (w_last) begin
               r_result <= w_res;
               r_neg    <= w_neg;
               r_err    <= w_err;
               r_done   <= 1'b1;
            end else begin
               r_cnt <= r_cnt - CW'(1);
            end
         end
      end
   end

   assign busy_o     = (r_state != IDLE);
   assign result_o   = r_result;
   assign negative_o = r_neg;
   assign err_o      = r_err;
   assign done_o     = r_done;

endmodule

// File: tb/tb_calc_alu.sv
// Self-checking bench for calc_alu: directed cases plus random operations against an arithmetic model.
// Latency checked per operation class.
// Covers ignored starts while busy and mid-operation reset.
module tb_calc_alu;
   import calc_pkg::*;

   localparam int W = CALC_DATA_WIDTH;

   logic           clk = 1'b0;
   logic           rst;
   logic [W-1:0]   num1_i;
   logic [W-1:0]   num2_i;
   logic [1:0]     operator_i;
   logic           start_calc_i;
   logic           busy_o;
   logic [2*W-1:0] result_o;
   logic           negative_o;
   logic           err_o;
   logic           done_o;

   int total = 0;
   int bad   = 0;

   logic [2*W-1:0] prev_res;
   logic           prev_neg;
   logic           prev_err;

   calc_alu #(.DATA_WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .num1_i       (num1_i),
      .num2_i       (num2_i),
      .operator_i   (operator_i),
      .start_calc_i (start_calc_i),
      .busy_o       (busy_o),
      .result_o     (result_o),
      .negative_o   (negative_o),
      .err_o        (err_o),
      .done_o       (done_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model straight from the arithmetic definition of each operator
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                                 output logic [2*W-1:0] res, output logic neg, output logic err,
                                 output int lat);
      longint unsigned la = longint'(a);
      longint unsigned lb = longint'(b);
      longint unsigned r  = 0;
      neg = 1'b0;
      err = 1'b0;
      lat = 2;
      case (op)
         2'd0: r = la + lb;
         2'd1: if (la >= lb) r = la - lb; else begin r = lb - la; neg = 1'b1; end
         2'd2: begin r = la * lb; lat = W + 1; end
         default: begin
`ifdef CALC_ALU_DIV_EN
            if (lb == 0) err = 1'b1;
            else begin r = ((la % lb) << W) | (la / lb); lat = W + 1; end
`else
            err = 1'b1;
`endif
         end
      endcase
      res = r[2*W-1:0];
   endfunction

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                         input bit noisy);
      logic [2*W-1:0] e_res;
      logic           e_neg;
      logic           e_err;
      int             e_lat;
      int             lat;
      bit             seen;
      model(a, b, op, e_res, e_neg, e_err, e_lat);
      @(negedge clk);
      num1_i = a; num2_i = b; operator_i = op; start_calc_i = 1'b1;
      @(posedge clk); #1;
      start_calc_i = 1'b0;
      num1_i = W'($urandom); num2_i = W'($urandom); operator_i = 2'($urandom);
      check("busy_after_start", busy_o, 1);
      check("hold_result", result_o, prev_res);
      check("hold_flags", {negative_o, err_o}, {prev_neg, prev_err});
      lat  = 0;
      seen = 1'b0;
      for (int i = 1; i <= 40 && !seen; i++) begin
         @(negedge clk);
         if (noisy && i <= e_lat) begin
            start_calc_i = 1'b1;
            num1_i = W'($urandom); num2_i = W'($urandom); operator_i = 2'($urandom);
         end
         @(posedge clk); #1;
         start_calc_i = 1'b0;
         if (done_o) begin
            seen = 1'b1;
            lat  = i + 1;
         end
      end
      if (!seen) begin
         check("done_timeout", 0, 1);
      end else begin
         check("latency", lat, e_lat);
         check("result", result_o, e_res);
         check("negative", negative_o, e_neg);
         check("err", err_o, e_err);
         check("busy_in_done", busy_o, 1);
      end
      prev_res = e_res;
      prev_neg = e_neg;
      prev_err = e_err;
      @(posedge clk); #1;
      check("done_pulse_width", done_o, 0);
      check("busy_fall", busy_o, 0);
      check("result_hold_idle", result_o, e_res);
      if (noisy) begin
         int extra = 0;
         for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done_o) extra++;
         end
         check("no_extra_done", extra, 0);
      end
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int           nd;
      rst = 1'b1; num1_i = '0; num2_i = '0; operator_i = 2'd0; start_calc_i = 1'b0;
      prev_res = '0; prev_neg = 1'b0; prev_err = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy_o, 0);
      check("rst_result", result_o, 0);
      check("rst_flags", {negative_o, err_o, done_o}, 3'b000);
      @(negedge clk); rst = 1'b0;

      run_op(16'd123,   16'd45,    2'd0, 1'b0);
      run_op(16'd10,    16'd25,    2'd1, 1'b0);
      run_op(16'd25,    16'd10,    2'd1, 1'b0);
      run_op(16'hFFFF,  16'hFFFF,  2'd0, 1'b0);
      run_op(16'd7,     16'd7,     2'd1, 1'b0);
      run_op(16'd65535, 16'd65535, 2'd2, 1'b0);
      run_op(16'd300,   16'd250,   2'd2, 1'b0);
      run_op(16'd1000,  16'd7,     2'd3, 1'b0);
      run_op(16'd5,     16'd0,     2'd3, 1'b0);
      run_op(16'd65535, 16'd1,     2'd3, 1'b0);
      run_op(16'd3,     16'd9,     2'd3, 1'b0);
      run_op(16'd300,   16'd250,   2'd2, 1'b1);

      // Abort a multiply partway through; nothing may complete afterwards
      @(negedge clk);
      num1_i = 16'd65535; num2_i = 16'd65535; operator_i = 2'd2; start_calc_i = 1'b1;
      @(posedge clk); #1;
      start_calc_i = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      check("abort_busy", busy_o, 0);
      check("abort_result", result_o, 0);
      check("abort_flags", {negative_o, err_o, done_o}, 3'b000);
      @(negedge clk); rst = 1'b0;
      nd = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #1;
         if (done_o) nd++;
      end
      check("abort_no_done", nd, 0);
      prev_res = '0; prev_neg = 1'b0; prev_err = 1'b0;
      run_op(16'd123, 16'd45, 2'd0, 1'b0);

      for (int k = 0; k < 40; k++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         case ($urandom_range(0, 5))
            0: rb = '0;
            1: ra = 16'hFFFF;
            2: rb = W'($urandom_range(1, 15));
            default: ;
         endcase
         run_op(ra, rb, 2'($urandom), (k % 8) == 3);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
